hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline, the successor to the single-issue stall/forward unit. It compares the register sources of the D and E stages against the destinations of E/M/W, using Tuse/Tnew, to produce stall, flush and forward selects. It adds E→D forwarding, a multiply/divide busy tracker that stalls HI/LO users, and a saturating stall-cycle performance counter. It sits beside the datapath; all its inputs come from the stage pipeline registers.

## Interface
Parameters:
- REG_AW, 5, register-address width
- TNEW_W, 2, width of Tuse/Tnew fields
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start
- CNT_W, 32, width of the stall performance counter

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- rs_d, rt_d  in  REG_AW  source registers of the D-stage instruction
- rs_e, rt_e  in  REG_AW  source registers of the E-stage instruction
- rs_use_d, rt_use_d  in  TNEW_W  Tuse of the D-stage sources; all-ones means not used
- wreg_e, wreg_m, wreg_w  in  REG_AW  destination register in E/M/W
- tnew_e, tnew_m, tnew_w  in  TNEW_W  remaining Tnew of the instruction in E/M/W
- regwrite_e, regwrite_m, regwrite_w  in  1  destination write enable per stage
- md_start_e  in  1  mult/div start pulse from E (1 cycle)
- md_is_div_e  in  1  qualifies md_start_e: 1 = div, 0 = mult
- md_use_d  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- fwd_a_d, fwd_b_d  out  2  D-stage select: 10 = E, 01 = M, 00 = RF
- fwd_a_e, fwd_b_e  out  2  E-stage select: 10 = M, 01 = W, 00 = pipe reg
- stall_f, stall_d, flush_e  out  1  freeze PC and IF/ID; bubble into ID/EX
- md_busy  out  1  mult/div unit busy (registered)
- stall_cnt  out  CNT_W  total stall cycles since reset, saturating

## Operation
- Match on stage X for source s: s == wreg_X, s != 0, and regwrite_X = 1.
- Data stall: a match on E with use < tnew_e, or a match on M with use < tnew_m, for either source. An all-ones Tuse never stalls.
- MD stall: md_use_d & (md_start_e | md_busy).
- stall = data stall | MD stall. It drives stall_f, stall_d and flush_e identically; all three are combinational.
- D forward, priority E > M: the E match with tnew_e == 0 gives 10; otherwise the M match with tnew_m == 0 gives 01; otherwise 00.
- E forward, priority M > W: the M match with tnew_m == 0 gives 10; otherwise the W match with tnew_w == 0 gives 01; otherwise 00.
- Register $0 never forwards and never stalls.
- Busy counter (md_cnt, width clog2(DIV_CYCLES+1)):
  - On md_start_e with md_cnt == 0, load DIV_CYCLES or MULT_CYCLES according to md_is_div_e.
  - Otherwise decrement while nonzero.
  - md_busy = (md_cnt != 0).
- md_start_e while md_busy is a protocol violation. It is ignored: no reload. An assertion flags it.
- stall_cnt increments in every cycle where stall = 1 and holds at all-ones.

## Timing
- Reset values: md_cnt = 0, md_busy = 0, stall_cnt = 0. The combinational outputs follow their inputs, with md_busy = 0 after reset.
- A reset asserted mid-operation clears md_cnt at the next edge and aborts the busy window.
- Start sampled at edge t with mult: md_busy is high for cycles t+1 … t+MULT_CYCLES, and low from t+MULT_CYCLES+1.
- In the start cycle itself, MD stall comes from md_start_e, so no gap opens.
- Forward and stall outputs have zero-cycle latency from their inputs.
- A data stall and an MD stall in the same cycle count as one stall cycle.
- At stall_cnt == all-ones with stall = 1, the counter stays at all-ones.

## Structure
- Package hazard_pkg holds:
  - TUSE_NONE (all-ones)
  - FWD_D_E/FWD_D_M/FWD_D_RF and FWD_E_M/FWD_E_W/FWD_E_PIPE encodings
  - default MULT_CYCLES/DIV_CYCLES values
- One sub-module, md_busy_tracker, holds md_cnt, its load/decrement logic and md_busy.
- Match, stall and forward logic plus stall_cnt stay in hazard_ctrl.

## Test plan
- Load-use: wreg_e = 8, tnew_e = 2, regwrite_e = 1, rs_d = 8, rs_use_d = 0 → stall_f/stall_d/flush_e = 1, stall_cnt +1. Next cycle the same in M with tnew_m = 1 → stall = 1.
- Forwarding priority:
  - rs_d = 5 matches E (tnew_e = 0) and M (tnew_m = 0) → fwd_a_d = 10.
  - rt_e = 5 matches M (tnew_m = 0) and W → fwd_b_e = 10.
  - With rs = 0 on all stages → every select is 00 and stall = 0.
- Mult window: md_start_e = 1, md_is_div_e = 0 at cycle 0 → md_busy high in cycles 1–5. md_use_d = 1 over cycles 0–6 → stall in 0–5, none in 6.
- Div with ignored restart: start div at cycle 0, then md_start_e again at cycle 3 → md_busy stays high through cycle 10 only; the assertion fires.
- Reset mid-busy: start div at cycle 0, reset at cycle 4 → md_busy = 0 and stall_cnt = 0 from cycle 5.
- Saturation: force stall_cnt to all-ones minus 1, hold stall for 3 cycles → stall_cnt ends at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the five-stage MIPS hazard/forwarding controller.
//   TUSE_NONE          : Tuse value meaning "source not read" (default Tuse width)
//   FWD_D_*            : D-stage forward select encodings (E / M / register file)
//   FWD_E_*            : E-stage forward select encodings (M / W / pipe register)
//   *_CYCLES_DEFAULT   : default multiply/divide busy windows
//   reg_match()        : source-vs-destination match with $0 and write-enable qualification
package hazard_pkg;

    localparam int unsigned TNEW_W_DEFAULT = 2;
    localparam logic [TNEW_W_DEFAULT-1:0] TUSE_NONE = '1;

    localparam logic [1:0] FWD_D_E    = 2'b10;
    localparam logic [1:0] FWD_D_M    = 2'b01;
    localparam logic [1:0] FWD_D_RF   = 2'b00;

    localparam logic [1:0] FWD_E_M    = 2'b10;
    localparam logic [1:0] FWD_E_W    = 2'b01;
    localparam logic [1:0] FWD_E_PIPE = 2'b00;

    localparam int unsigned MULT_CYCLES_DEFAULT = 5;
    localparam int unsigned DIV_CYCLES_DEFAULT  = 10;

    // Addresses are zero-extended to 32 bits by the caller so one helper serves any REG_AW.
    function automatic logic reg_match(input logic [31:0] src, input logic [31:0] wreg,
                                       input logic we);
        return we && (src == wreg) && (src != 32'd0);
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Multiply/divide busy tracker.
//   clk, reset  : clock and synchronous active-high reset
//   md_start    : 1-cycle start pulse from the E stage
//   md_is_div   : qualifies md_start, 1 = divide, 0 = multiply
//   md_busy     : registered busy flag (md_cnt != 0)
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0] md_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (md_start && (md_cnt == '0)) begin
            md_cnt <= md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            // A start while busy falls through here: the running window is not extended.
            md_cnt <= md_cnt - CW'(1);
        end
    end

    assign md_busy = (md_cnt != '0);

    a_no_start_while_busy : assert property (@(posedge clk) disable iff (reset)
        !(md_start && md_busy))
        else $warning("md_start_e while md_busy: start ignored");

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage MIPS pipeline.
//   clk, reset                    : clock, synchronous active-high reset
//   rs_d/rt_d, rs_e/rt_e          : source registers of the D and E instructions
//   rs_use_d/rt_use_d             : Tuse of the D sources (all-ones = not read)
//   wreg_*/tnew_*/regwrite_*      : destination, remaining Tnew and write enable in E/M/W
//   md_start_e/md_is_div_e        : mult/div start pulse and kind
//   md_use_d                      : D instruction touches the mult/div unit or HI/LO
//   fwd_a_d/fwd_b_d               : D forward select (10 = E, 01 = M, 00 = RF)
//   fwd_a_e/fwd_b_e               : E forward select (10 = M, 01 = W, 00 = pipe reg)
//   stall_f/stall_d/flush_e       : combinational stall / bubble controls
//   md_busy                       : registered mult/div busy flag
//   stall_cnt                     : saturating count of stall cycles since reset
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned TNEW_W      = TNEW_W_DEFAULT,
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [TNEW_W-1:0] rs_use_d,
    input  logic [TNEW_W-1:0] rt_use_d,
    input  logic [REG_AW-1:0] wreg_e,
    input  logic [REG_AW-1:0] wreg_m,
    input  logic [REG_AW-1:0] wreg_w,
    input  logic [TNEW_W-1:0] tnew_e,
    input  logic [TNEW_W-1:0] tnew_m,
    input  logic [TNEW_W-1:0] tnew_w,
    input  logic              regwrite_e,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              md_start_e,
    input  logic              md_is_div_e,
    input  logic              md_use_d,
    output logic [1:0]        fwd_a_d,
    output logic [1:0]        fwd_b_d,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [TNEW_W-1:0] USE_NONE = '1;

    logic rs_d_me, rs_d_mm, rt_d_me, rt_d_mm;
    logic rs_e_mm, rs_e_mw, rt_e_mm, rt_e_mw;
    logic stall_rs, stall_rt, data_stall, md_stall, stall;

    always_comb begin
        rs_d_me = reg_match(32'(rs_d), 32'(wreg_e), regwrite_e);
        rs_d_mm = reg_match(32'(rs_d), 32'(wreg_m), regwrite_m);
        rt_d_me = reg_match(32'(rt_d), 32'(wreg_e), regwrite_e);
        rt_d_mm = reg_match(32'(rt_d), 32'(wreg_m), regwrite_m);
        rs_e_mm = reg_match(32'(rs_e), 32'(wreg_m), regwrite_m);
        rs_e_mw = reg_match(32'(rs_e), 32'(wreg_w), regwrite_w);
        rt_e_mm = reg_match(32'(rt_e), 32'(wreg_m), regwrite_m);
        rt_e_mw = reg_match(32'(rt_e), 32'(wreg_w), regwrite_w);
    end

    // Stall when the producer's value arrives later than the consumer needs it.
    always_comb begin
        stall_rs   = (rs_use_d != USE_NONE) &&
                     ((rs_d_me && (rs_use_d < tnew_e)) || (rs_d_mm && (rs_use_d < tnew_m)));
        stall_rt   = (rt_use_d != USE_NONE) &&
                     ((rt_d_me && (rt_use_d < tnew_e)) || (rt_d_mm && (rt_use_d < tnew_m)));
        data_stall = stall_rs || stall_rt;
        // md_start_e covers the start cycle before md_busy has risen.
        md_stall   = md_use_d && (md_start_e || md_busy);
        stall      = data_stall || md_stall;
    end

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

    always_comb begin
        fwd_a_d = FWD_D_RF;
        if (rs_d_me && (tnew_e == '0))      fwd_a_d = FWD_D_E;
        else if (rs_d_mm && (tnew_m == '0)) fwd_a_d = FWD_D_M;

        fwd_b_d = FWD_D_RF;
        if (rt_d_me && (tnew_e == '0))      fwd_b_d = FWD_D_E;
        else if (rt_d_mm && (tnew_m == '0)) fwd_b_d = FWD_D_M;

        fwd_a_e = FWD_E_PIPE;
        if (rs_e_mm && (tnew_m == '0))      fwd_a_e = FWD_E_M;
        else if (rs_e_mw && (tnew_w == '0)) fwd_a_e = FWD_E_W;

        fwd_b_e = FWD_E_PIPE;
        if (rt_e_mm && (tnew_m == '0))      fwd_b_e = FWD_E_M;
        else if (rt_e_mw && (tnew_w == '0)) fwd_b_e = FWD_E_W;
    end

    md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_tracker (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start_e),
        .md_is_div (md_is_div_e),
        .md_busy   (md_busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic [1:0] rs_use_d, rt_use_d, tnew_e, tnew_m, tnew_w;
    logic       regwrite_e, regwrite_m, regwrite_w;
    logic       md_start_e, md_is_div_e, md_use_d;
    logic [1:0] fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
    logic       stall_f, stall_d, flush_e, md_busy;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl #(
        .REG_AW (5), .TNEW_W (2), .MULT_CYCLES (5), .DIV_CYCLES (10), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .reset (reset),
        .rs_d (rs_d), .rt_d (rt_d), .rs_e (rs_e), .rt_e (rt_e),
        .rs_use_d (rs_use_d), .rt_use_d (rt_use_d),
        .wreg_e (wreg_e), .wreg_m (wreg_m), .wreg_w (wreg_w),
        .tnew_e (tnew_e), .tnew_m (tnew_m), .tnew_w (tnew_w),
        .regwrite_e (regwrite_e), .regwrite_m (regwrite_m), .regwrite_w (regwrite_w),
        .md_start_e (md_start_e), .md_is_div_e (md_is_div_e), .md_use_d (md_use_d),
        .fwd_a_d (fwd_a_d), .fwd_b_d (fwd_b_d), .fwd_a_e (fwd_a_e), .fwd_b_e (fwd_b_e),
        .stall_f (stall_f), .stall_d (stall_d), .flush_e (flush_e),
        .md_busy (md_busy), .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [1:0]       fad, fbd, fae, fbe;
        logic             stall;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    int               vectors = 0;
    int               miscompares = 0;
    string            cur = "";
    logic [CNT_W-1:0] exp_cnt = '0;

    // Scoreboard consumer: one expected record per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if ({fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, stall_f, stall_d, flush_e, md_busy, stall_cnt}
                !== {e.fad, e.fbd, e.fae, e.fbe, e.stall, e.stall, e.stall, e.busy, e.cnt}) begin
                miscompares++;
                $display("FAIL %s @%0t: got fad=%b fbd=%b fae=%b fbe=%b sf/sd/fe=%b%b%b busy=%b cnt=%0d ; want fad=%b fbd=%b fae=%b fbe=%b stall=%b busy=%b cnt=%0d",
                         e.name, $time, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, stall_f, stall_d,
                         flush_e, md_busy, stall_cnt, e.fad, e.fbd, e.fae, e.fbe, e.stall,
                         e.busy, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stall_cnt is the bench's own saturating count of expected stall cycles.
    task automatic push(input logic [1:0] fad, input logic [1:0] fbd, input logic [1:0] fae,
                        input logic [1:0] fbe, input logic st, input logic bz);
        exp_t e;
        e.name = cur; e.fad = fad; e.fbd = fbd; e.fae = fae; e.fbe = fbe;
        e.stall = st; e.busy = bz; e.cnt = exp_cnt;
        sb.push_back(e);
        if (st && (exp_cnt != '1)) exp_cnt++;
    endtask

    task automatic set_idle();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        rs_use_d = TUSE_NONE; rt_use_d = TUSE_NONE;
        wreg_e = 0; wreg_m = 0; wreg_w = 0;
        tnew_e = 0; tnew_m = 0; tnew_w = 0;
        regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
        md_start_e = 0; md_is_div_e = 0; md_use_d = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        cur = "reset";
        do_reset();
        push(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_load_use();
        cur = "load_use_e";
        set_idle(); wreg_e = 8; tnew_e = 2; regwrite_e = 1; rs_d = 8; rs_use_d = 0;
        push(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        cur = "load_use_m";
        set_idle(); wreg_m = 8; tnew_m = 1; regwrite_m = 1; rs_d = 8; rs_use_d = 0;
        push(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        cur = "w_only_no_d_fwd";
        set_idle(); wreg_w = 8; regwrite_w = 1; rs_d = 8; rs_use_d = 0;
        push(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        cur = "tuse_none";
        set_idle(); wreg_e = 8; tnew_e = 2; regwrite_e = 1; rt_d = 8; rt_use_d = TUSE_NONE;
        push(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        cur = "rt_use_lt_tnew";
        set_idle(); wreg_e = 8; tnew_e = 2; regwrite_e = 1; rt_d = 8; rt_use_d = 1;
        push(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        cur = "use_eq_tnew";
        set_idle(); wreg_e = 8; tnew_e = 1; regwrite_e = 1; rs_d = 8; rs_use_d = 1;
        push(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        cur = "load_use_count";
        set_idle();
        push(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
    endtask

    task automatic test_fwd_priority();
        cur = "fwd_e_over_m";
        set_idle(); rs_d = 5; rs_use_d = 0; rt_e = 5;
        wreg_e = 5; regwrite_e = 1; wreg_m = 5; regwrite_m = 1; wreg_w = 5; regwrite_w = 1;
        push(2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0); tick();
        cur = "fwd_m_and_w";
        set_idle(); rs_d = 6; rs_use_d = 0; rt_d = 6; rt_use_d = 1; rs_e = 6; rt_e = 9;
        wreg_e = 7; regwrite_e = 1; wreg_m = 6; regwrite_m = 1; wreg_w = 9; regwrite_w = 1;
        push(2'b01, 2'b01, 2'b10, 2'b01, 1'b0, 1'b0); tick();
        cur = "fwd_regwrite_off";
        regwrite_m = 0; regwrite_w = 0;
        push(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        cur = "fwd_m_not_ready";
        set_idle(); rs_d = 6; rs_use_d = 2; rs_e = 6;
        wreg_m = 6; tnew_m = 1; regwrite_m = 1; wreg_w = 6; regwrite_w = 1;
        push(2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0); tick();
        cur = "fwd_e_not_ready";
        set_idle(); rs_d = 3; rs_use_d = 1;
        wreg_e = 3; tnew_e = 1; regwrite_e = 1; wreg_m = 3; regwrite_m = 1;
        push(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        cur = "reg_zero";
        set_idle(); rs_use_d = 0; rt_use_d = 0;
        tnew_e = 3; tnew_m = 3; regwrite_e = 1; regwrite_m = 1; regwrite_w = 1;
        push(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
    endtask

    task automatic test_mult_window();
        cur = "mult_window";
        for (int c = 0; c <= 7; c++) begin
            set_idle();
            md_use_d = (c <= 6);
            md_start_e = (c == 0);
            push(2'b00, 2'b00, 2'b00, 2'b00, c <= 5, (c >= 1) && (c <= 5));
            tick();
        end
    endtask

    task automatic test_div_restart();
        cur = "div_restart";
        for (int c = 0; c <= 12; c++) begin
            set_idle();
            md_is_div_e = 1;
            md_start_e = (c == 0) || (c == 3);
            push(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, (c >= 1) && (c <= 10));
            tick();
        end
    endtask

    task automatic test_reset_mid_busy();
        cur = "reset_mid_busy";
        for (int c = 0; c <= 5; c++) begin
            set_idle();
            md_is_div_e = 1;
            md_start_e = (c == 0);
            md_use_d = (c <= 4);
            reset = (c == 4);
            if (c == 5) exp_cnt = '0;
            push(2'b00, 2'b00, 2'b00, 2'b00, c <= 4, (c >= 1) && (c <= 4));
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        cur = "saturation";
        for (int i = 0; i <= 16; i++) begin
            set_idle(); wreg_e = 8; tnew_e = 2; regwrite_e = 1; rs_d = 8; rs_use_d = 0;
            push(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
            tick();
        end
        set_idle();
        push(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (stall_cnt !== {CNT_W{1'b1}}) begin
            miscompares++;
            $display("FAIL sat_hold: stall_cnt got %0d want %0d", stall_cnt, {CNT_W{1'b1}});
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        tick();
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_mult_window();
        test_div_restart();
        test_reset_mid_busy();
        test_saturation();
        tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected records left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
